// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: load-use stalls, branch flushes, memory freezes.
// Define HAZARD_FORWARD_EN to build in EX-stage forwarding (otherwise any RAW hazard stalls).
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_de,
    input  logic [REG_ADDR_W-1:0] rs2_de,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  regwrite_ex,
    input  logic                  regwrite_mem,
    input  logic                  regwrite_wb,
    input  logic                  memtoreg_ex,
    input  logic                  branch_taken_ex,
    input  logic                  mem_busy,
    output logic                  en_fe_n,
    output logic                  en_de_n,
    output logic                  en_ex_n,
    output logic                  en_mem_n,
    output logic                  clrBU,
    output logic                  clr_ex,
    output logic [1:0]            fwd_a_ex,
    output logic [1:0]            fwd_b_ex
);
    typedef enum logic [1:0] {RUN, LSTALL, FLUSH, MWAIT} state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] STALL_LD = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d, sav_q, sav_d, cur;
    logic [2:0] cnt_q, cnt_d, sav_cnt_q, sav_cnt_d, cur_cnt;
    logic       load_use, raw_haz;
    logic [1:0] fa, fb;

    function automatic logic hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

    assign load_use = memtoreg_ex
                    & (hit(regwrite_ex, rd_ex, rs1_de) | hit(regwrite_ex, rd_ex, rs2_de));

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] fsel(input logic [REG_ADDR_W-1:0] rs);
        if (hit(regwrite_mem, rd_mem, rs)) return 2'b10;
        if (hit(regwrite_wb, rd_wb, rs))   return 2'b01;
        return 2'b00;
    endfunction

    assign raw_haz = 1'b0;
    assign fa      = fsel(rs1_ex);
    assign fb      = fsel(rs2_ex);
`else
    logic unused_ex;

    assign raw_haz = hit(regwrite_ex, rd_ex, rs1_de)   | hit(regwrite_ex, rd_ex, rs2_de)
                   | hit(regwrite_mem, rd_mem, rs1_de) | hit(regwrite_mem, rd_mem, rs2_de)
                   | hit(regwrite_wb, rd_wb, rs1_de)   | hit(regwrite_wb, rd_wb, rs2_de);
    assign fa        = 2'b00;
    assign fb        = 2'b00;
    assign unused_ex = ^{rs1_ex, rs2_ex};
`endif

    always_comb begin
        cur     = state_q;
        cur_cnt = cnt_q;
        // Once memory is ready, MWAIT behaves as the operation it interrupted
        if (state_q == MWAIT) begin
            cur     = sav_q;
            cur_cnt = sav_cnt_q;
        end
        state_d   = cur;
        cnt_d     = cur_cnt;
        sav_d     = sav_q;
        sav_cnt_d = sav_cnt_q;
        en_fe_n   = 1'b0;
        en_de_n   = 1'b0;
        en_ex_n   = 1'b0;
        en_mem_n  = 1'b0;
        clrBU     = 1'b0;
        clr_ex    = 1'b0;
        fwd_a_ex  = fa;
        fwd_b_ex  = fb;
        if (mem_busy) begin
            {en_fe_n, en_de_n, en_ex_n, en_mem_n} = 4'hf;
            state_d   = MWAIT;
            sav_d     = cur;
            sav_cnt_d = cur_cnt;
        end else if (branch_taken_ex) begin
            clrBU   = 1'b1;
            clr_ex  = 1'b1;
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d   = FLUSH_LD;
        end else begin
            unique case (cur)
                FLUSH: begin
                    clrBU   = 1'b1;
                    clr_ex  = 1'b1;
                    cnt_d   = cur_cnt - 3'd1;
                    state_d = (cur_cnt == 3'd1) ? RUN : FLUSH;
                end
                LSTALL: begin
                    en_fe_n = 1'b1;
                    en_de_n = 1'b1;
                    clr_ex  = 1'b1;
                    cnt_d   = cur_cnt - 3'd1;
                    state_d = (cur_cnt == 3'd1) ? RUN : LSTALL;
                end
                default: begin
                    if (load_use) begin
                        en_fe_n = 1'b1;
                        en_de_n = 1'b1;
                        clr_ex  = 1'b1;
                        state_d = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
                        cnt_d   = STALL_LD;
                    end else if (raw_haz) begin
                        en_fe_n = 1'b1;
                        en_de_n = 1'b1;
                        clr_ex  = 1'b1;
                    end
                end
            endcase
        end
        if (rst) begin
            {en_fe_n, en_de_n, en_ex_n, en_mem_n} = 4'h0;
            clrBU    = 1'b1;
            clr_ex   = 1'b1;
            fwd_a_ex = 2'b00;
            fwd_b_ex = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            sav_q     <= RUN;
            sav_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sav_q     <= sav_d;
            sav_cnt_q <= sav_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios then random traffic vs a cycle-count model.
// Expected values adapt to whether HAZARD_FORWARD_EN is defined.
module tb_hazard_ctrl_unit;
    localparam int AW = 5;
    localparam int FC = 3;
    localparam int LC = 2;

    localparam logic [9:0] NORMAL = 10'b0000_00_0000;
    localparam logic [9:0] RSTV   = 10'b0000_11_0000;
    localparam logic [9:0] FLSH   = 10'b0000_11_0000;
    localparam logic [9:0] STALL  = 10'b1100_01_0000;
    localparam logic [9:0] FREEZE = 10'b1111_00_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic          regwrite_ex, regwrite_mem, regwrite_wb;
    logic          memtoreg_ex, branch_taken_ex, mem_busy;
    logic          en_fe_n, en_de_n, en_ex_n, en_mem_n, clrBU, clr_ex;
    logic [1:0]    fwd_a_ex, fwd_b_ex;

    int            checks = 0;
    int            failures = 0;
    int            flush_left = 0;
    int            stall_left = 0;
    int            fl_n, sl_n;
    logic [9:0]    exp_v, obs_v;

    hazard_ctrl_unit #(
        .REG_ADDR_W(AW),
        .FLUSH_CYCLES(FC),
        .LOAD_STALL_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem),
        .regwrite_wb(regwrite_wb), .memtoreg_ex(memtoreg_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .en_fe_n(en_fe_n), .en_de_n(en_de_n),
        .en_ex_n(en_ex_n), .en_mem_n(en_mem_n),
        .clrBU(clrBU), .clr_ex(clr_ex),
        .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex)
    );

    always #5 clk = ~clk;

    function automatic logic hit(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] rs);
        return we && (rd != 0) && (rd == rs);
    endfunction

    function automatic logic [1:0] fsel(input logic [AW-1:0] rs);
        if (hit(regwrite_mem, rd_mem, rs)) return 2'b10;
        if (hit(regwrite_wb, rd_wb, rs))   return 2'b01;
        return 2'b00;
    endfunction

    // Model: a freeze leaves the remaining flush/stall counts untouched
    task automatic model_eval();
        logic       lu;
        logic [5:0] ctl;
        logic [3:0] fw;
`ifndef HAZARD_FORWARD_EN
        logic       raw;
        raw = hit(regwrite_ex, rd_ex, rs1_de) || hit(regwrite_ex, rd_ex, rs2_de)
           || hit(regwrite_mem, rd_mem, rs1_de) || hit(regwrite_mem, rd_mem, rs2_de)
           || hit(regwrite_wb, rd_wb, rs1_de) || hit(regwrite_wb, rd_wb, rs2_de);
`endif
        lu   = memtoreg_ex && (hit(regwrite_ex, rd_ex, rs1_de) || hit(regwrite_ex, rd_ex, rs2_de));
        fl_n = flush_left;
        sl_n = stall_left;
        ctl  = NORMAL[9:4];
        if (rst) begin
            ctl  = RSTV[9:4];
            fl_n = 0;
            sl_n = 0;
        end else if (mem_busy) begin
            ctl = FREEZE[9:4];
        end else if (branch_taken_ex) begin
            ctl  = FLSH[9:4];
            fl_n = FC - 1;
            sl_n = 0;
        end else if (flush_left > 0) begin
            ctl  = FLSH[9:4];
            fl_n = flush_left - 1;
        end else if (stall_left > 0) begin
            ctl  = STALL[9:4];
            sl_n = stall_left - 1;
        end else if (lu) begin
            ctl  = STALL[9:4];
            sl_n = LC - 1;
        end
`ifndef HAZARD_FORWARD_EN
        else if (raw) begin
            ctl = STALL[9:4];
        end
`endif
        fw = 4'b0000;
`ifdef HAZARD_FORWARD_EN
        if (!rst) fw = {fsel(rs1_ex), fsel(rs2_ex)};
`endif
        exp_v = {ctl, fw};
    endtask

    task automatic cyc(input string tag, input bit use_lit, input logic [9:0] lit);
        @(negedge clk);
        model_eval();
        obs_v = {en_fe_n, en_de_n, en_ex_n, en_mem_n, clrBU, clr_ex, fwd_a_ex, fwd_b_ex};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
        end
        if (use_lit) begin
            checks++;
            assert (obs_v === lit) else begin
                failures++;
                $error("FAIL %s_lit observed=%b expected=%b", tag, obs_v, lit);
            end
        end
        @(posedge clk);
        flush_left = fl_n;
        stall_left = sl_n;
        #1;
    endtask

    task automatic clear_in();
        rs1_de = 0; rs2_de = 0; rs1_ex = 0; rs2_ex = 0;
        rd_ex = 0; rd_mem = 0; rd_wb = 0;
        regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
        memtoreg_ex = 0; branch_taken_ex = 0; mem_busy = 0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        branch_taken_ex = 1'b1;
        cyc("reset0", 1, RSTV);
        cyc("reset1", 1, RSTV);
        rst = 1'b0;
        branch_taken_ex = 1'b0;
        cyc("post_reset", 1, NORMAL);

        memtoreg_ex = 1; regwrite_ex = 1; rd_ex = 5; rs2_de = 5;
        cyc("lu_c0", 1, STALL);
        clear_in();
        cyc("lu_c1", 1, STALL);
        cyc("lu_done", 1, NORMAL);
        memtoreg_ex = 1; regwrite_ex = 1; rd_ex = 0; rs2_de = 5;
        cyc("lu_r0", 1, NORMAL);
        clear_in();

        branch_taken_ex = 1;
        memtoreg_ex = 1; regwrite_ex = 1; rd_ex = 6; rs1_de = 6;
        cyc("br_c0", 1, FLSH);
        clear_in();
        cyc("br_c1", 1, FLSH);
        cyc("br_c2", 1, FLSH);
        cyc("br_done", 1, NORMAL);

        branch_taken_ex = 1;
        cyc("mw_fl0", 1, FLSH);
        branch_taken_ex = 0;
        mem_busy = 1;
        for (int i = 0; i < 4; i++) cyc("mw_freeze", 1, FREEZE);
        mem_busy = 0;
        cyc("mw_fl1", 1, FLSH);
        cyc("mw_fl2", 1, FLSH);
        cyc("mw_done", 1, NORMAL);

        rs1_ex = 7; rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1;
`ifdef HAZARD_FORWARD_EN
        cyc("fwd_mem", 1, 10'b0000_00_1000);
        regwrite_mem = 0;
        cyc("fwd_wb", 1, 10'b0000_00_0100);
        rd_wb = 0;
        cyc("fwd_none", 1, NORMAL);
`else
        cyc("fwd_off_mem", 1, NORMAL);
        regwrite_mem = 0;
        cyc("fwd_off_wb", 1, NORMAL);
`endif
        clear_in();
        rs1_de = 3; rd_mem = 3; regwrite_mem = 1;
`ifdef HAZARD_FORWARD_EN
        cyc("raw_fwd", 1, NORMAL);
`else
        cyc("raw_stall", 1, STALL);
`endif
        clear_in();
        cyc("raw_done", 1, NORMAL);

        branch_taken_ex = 1;
        cyc("rst_mid_fl", 1, FLSH);
        branch_taken_ex = 0;
        rst = 1;
        cyc("rst_abort", 1, RSTV);
        rst = 0;
        cyc("rst_after", 1, NORMAL);

        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(59) == 0);
            mem_busy        = ($urandom_range(5) == 0);
            branch_taken_ex = ($urandom_range(7) == 0);
            memtoreg_ex     = ($urandom_range(2) == 0);
            regwrite_ex     = ($urandom_range(1) == 0);
            regwrite_mem    = ($urandom_range(1) == 0);
            regwrite_wb     = ($urandom_range(1) == 0);
            rs1_de = AW'($urandom_range(3));
            rs2_de = AW'($urandom_range(3));
            rs1_ex = AW'($urandom_range(3));
            rs2_ex = AW'($urandom_range(3));
            rd_ex  = AW'($urandom_range(3));
            rd_mem = AW'($urandom_range(3));
            rd_wb  = AW'($urandom_range(3));
            cyc("rand", 0, NORMAL);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
